// File: rtl/alu_ctrl_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_seq_if
// Description : Control/feedback bundle between alu_ctrl_seq and the Mini SRC
//               datapath (instruction feedback in, control strobes out).
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_ctrl_seq_if;
  logic [31:0] IR;
  logic        Mem_ready;
  logic        Stop;
  logic [15:0] Rin;
  logic [15:0] Rout;
  logic        PCin;
  logic        PCout;
  logic        IncPC;
  logic        MARin;
  logic        MDRin;
  logic        MDRout;
  logic        IRin;
  logic        Yin;
  logic        ZLowin;
  logic        ZHighin;
  logic        ZLowout;
  logic        ZHighout;
  logic        HIin;
  logic        LOin;
  logic        Read;
  logic [4:0]  OP;
  logic        Run;

  modport master (
    input  IR, Mem_ready, Stop,
    output Rin, Rout, PCin, PCout, IncPC, MARin, MDRin, MDRout, IRin, Yin,
           ZLowin, ZHighin, ZLowout, ZHighout, HIin, LOin, Read, OP, Run
  );

  modport slave (
    output IR, Mem_ready, Stop,
    input  Rin, Rout, PCin, PCout, IncPC, MARin, MDRin, MDRout, IRin, Yin,
           ZLowin, ZHighin, ZLowout, ZHighout, HIin, LOin, Read, OP, Run
  );
endinterface
`default_nettype wire

// File: rtl/alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_seq
// Description : Hardwired fetch/execute sequencer for Mini SRC register-to-
//               register ALU instructions; outputs decoded from state and IR.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_seq #(
  parameter logic [4:0] HALT_OP = 5'b11011
) (
  input  wire logic       Clock,
  input  wire logic       Clear,
  alu_ctrl_seq_if.master  bus
);

  typedef enum logic [3:0] {
    ST_RST  = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_HALT = 4'd8
  } state_e;

  typedef enum logic [2:0] {
    CL_ILLEGAL = 3'd0,
    CL_BINARY  = 3'd1,
    CL_UNARY   = 3'd2,
    CL_WIDE    = 3'd3,
    CL_HALT    = 3'd4
  } opc_class_e;

  state_e     state_q;
  state_e     state_d;
  opc_class_e opc_class;

  logic [4:0] opcode;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rc;
  logic       unused_ir_bits;

  assign opcode         = bus.IR[31:27];
  assign ra             = bus.IR[26:23];
  assign rb             = bus.IR[22:19];
  assign rc             = bus.IR[18:15];
  assign unused_ir_bits = ^bus.IR[14:0];

  function automatic logic [15:0] reg_sel(input logic [3:0] idx);
    reg_sel = 16'h0001 << idx;
  endfunction

  // HALT_OP is checked first so a parameter override always wins.
  always_comb begin
    opc_class = CL_ILLEGAL;
    if (opcode == HALT_OP) begin
      opc_class = CL_HALT;
    end else begin
      case (opcode)
        5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
        5'b01000, 5'b01001, 5'b01010, 5'b01011: opc_class = CL_BINARY;
        5'b10001, 5'b10010:                     opc_class = CL_UNARY;
        5'b01111, 5'b10000:                     opc_class = CL_WIDE;
        default:                                opc_class = CL_ILLEGAL;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q <= ST_RST;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bus.Rin      = 16'h0000;
    bus.Rout     = 16'h0000;
    bus.PCin     = 1'b0;
    bus.PCout    = 1'b0;
    bus.IncPC    = 1'b0;
    bus.MARin    = 1'b0;
    bus.MDRin    = 1'b0;
    bus.MDRout   = 1'b0;
    bus.IRin     = 1'b0;
    bus.Yin      = 1'b0;
    bus.ZLowin   = 1'b0;
    bus.ZHighin  = 1'b0;
    bus.ZLowout  = 1'b0;
    bus.ZHighout = 1'b0;
    bus.HIin     = 1'b0;
    bus.LOin     = 1'b0;
    bus.Read     = 1'b0;
    bus.OP       = 5'b00000;
    bus.Run      = 1'b0;

    case (state_q)
      ST_RST: begin
        state_d = ST_T0;
      end

      ST_T0: begin
        bus.Run   = 1'b1;
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.PCin  = 1'b1;
        state_d   = ST_T1;
      end

      ST_T1: begin
        bus.Run   = 1'b1;
        bus.Read  = 1'b1;
        bus.MDRin = 1'b1;
        if (bus.Mem_ready) begin
          state_d = ST_T2;
        end
      end

      // IR is reloaded on the edge leaving T2, so decode waits for T3.
      ST_T2: begin
        bus.Run    = 1'b1;
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
        state_d    = ST_T3;
      end

      ST_T3: begin
        bus.Run = 1'b1;
        case (opc_class)
          CL_BINARY, CL_WIDE: begin
            bus.Rout = reg_sel(rb);
            bus.Yin  = 1'b1;
            state_d  = ST_T4;
          end
          CL_UNARY: begin
            state_d = ST_T4;
          end
          CL_HALT: begin
            state_d = ST_HALT;
          end
          default: begin
            state_d = bus.Stop ? ST_HALT : ST_T0;
          end
        endcase
      end

      ST_T4: begin
        bus.Run    = 1'b1;
        bus.OP     = opcode;
        bus.ZLowin = 1'b1;
        bus.Rout   = (opc_class == CL_UNARY) ? reg_sel(rb) : reg_sel(rc);
        if (opc_class == CL_WIDE) begin
          bus.ZHighin = 1'b1;
        end
        state_d = ST_T5;
      end

      ST_T5: begin
        bus.Run     = 1'b1;
        bus.ZLowout = 1'b1;
        if (opc_class == CL_WIDE) begin
          bus.LOin = 1'b1;
          state_d  = ST_T6;
        end else begin
          bus.Rin = reg_sel(ra);
          state_d = bus.Stop ? ST_HALT : ST_T0;
        end
      end

      ST_T6: begin
        bus.Run      = 1'b1;
        bus.ZHighout = 1'b1;
        bus.HIin     = 1'b1;
        state_d      = bus.Stop ? ST_HALT : ST_T0;
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_RST;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_ctrl_seq
// Description : Scoreboard bench for alu_ctrl_seq; expected per-cycle control
//               vectors are queued per instruction and compared each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_ctrl_seq;

  typedef struct packed {
    logic [15:0] rin;
    logic [15:0] rout;
    logic        pcin;
    logic        pcout;
    logic        incpc;
    logic        marin;
    logic        mdrin;
    logic        mdrout;
    logic        irin;
    logic        yin;
    logic        zlowin;
    logic        zhighin;
    logic        zlowout;
    logic        zhighout;
    logic        hiin;
    logic        loin;
    logic        read;
    logic [4:0]  op;
    logic        run;
  } ctl_t;

  typedef struct {
    ctl_t        exp;
    bit          mr;
    bit          stp;
    bit          ld;
    logic [31:0] ir;
  } entry_t;

  logic Clock = 1'b0;
  logic Clear = 1'b0;

  alu_ctrl_seq_if bus();

  alu_ctrl_seq #(.HALT_OP(5'b11011)) dut (
    .Clock (Clock),
    .Clear (Clear),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  entry_t sb[$];
  int     n_vec     = 0;
  int     n_miss    = 0;
  int     pcin_seen = 0;

  function automatic ctl_t sample();
    ctl_t s;
    s.rin = bus.Rin;       s.rout = bus.Rout;
    s.pcin = bus.PCin;     s.pcout = bus.PCout;   s.incpc = bus.IncPC;
    s.marin = bus.MARin;   s.mdrin = bus.MDRin;   s.mdrout = bus.MDRout;
    s.irin = bus.IRin;     s.yin = bus.Yin;       s.zlowin = bus.ZLowin;
    s.zhighin = bus.ZHighin; s.zlowout = bus.ZLowout; s.zhighout = bus.ZHighout;
    s.hiin = bus.HIin;     s.loin = bus.LOin;     s.read = bus.Read;
    s.op = bus.OP;         s.run = bus.Run;
    return s;
  endfunction

  function automatic bit rbit();
    return bit'($urandom_range(0, 1));
  endfunction

  task automatic push(input ctl_t c, input bit mr, input bit stp, input bit ld, input logic [31:0] ir);
    entry_t e;
    e.exp = c; e.mr = mr; e.stp = stp; e.ld = ld; e.ir = ir;
    sb.push_back(e);
  endtask

  // stop_mode: 0 Stop low, 1 Stop random except low at the end, 2 Stop high from T4 on.
  task automatic gen(input logic [31:0] instr, input int waits, input int stop_mode);
    ctl_t        c;
    logic [4:0]  opc;
    logic [15:0] one;
    bit          is_bin, is_un, is_wide, is_halt, stop_end, halted;
    opc      = instr[31:27];
    one      = 16'h0001;
    is_bin   = opc inside {5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                           5'b01000, 5'b01001, 5'b01010, 5'b01011};
    is_un    = opc inside {5'b10001, 5'b10010};
    is_wide  = opc inside {5'b01111, 5'b10000};
    is_halt  = (opc == 5'b11011);
    stop_end = (stop_mode == 2);

    c = '0; c.run = 1; c.pcout = 1; c.marin = 1; c.incpc = 1; c.pcin = 1;
    push(c, rbit(), (stop_mode == 1) ? rbit() : 1'b0, 0, 0);
    for (int w = 0; w <= waits; w++) begin
      c = '0; c.run = 1; c.read = 1; c.mdrin = 1;
      push(c, (w == waits), (stop_mode == 1) ? rbit() : 1'b0, 0, 0);
    end
    c = '0; c.run = 1; c.mdrout = 1; c.irin = 1;
    push(c, rbit(), (stop_mode == 1) ? rbit() : 1'b0, 1, instr);

    c = '0; c.run = 1;
    if (is_bin || is_wide) begin
      c.rout = one << instr[22:19];
      c.yin  = 1;
    end
    if (is_bin || is_un || is_wide) begin
      push(c, rbit(), (stop_mode == 1) ? rbit() : 1'b0, 0, 0);
      c = '0; c.run = 1; c.op = opc; c.zlowin = 1; c.zhighin = is_wide;
      c.rout = one << (is_un ? instr[22:19] : instr[18:15]);
      push(c, rbit(), (stop_mode == 1) ? rbit() : stop_end, 0, 0);
      c = '0; c.run = 1; c.zlowout = 1;
      if (is_wide) begin
        c.loin = 1;
        push(c, rbit(), (stop_mode == 1) ? rbit() : stop_end, 0, 0);
        c = '0; c.run = 1; c.zhighout = 1; c.hiin = 1;
      end else begin
        c.rin = one << instr[26:23];
      end
      push(c, rbit(), stop_end, 0, 0);
      halted = stop_end;
    end else if (is_halt) begin
      push(c, rbit(), rbit(), 0, 0);
      halted = 1;
    end else begin
      push(c, rbit(), stop_end, 0, 0);
      halted = stop_end;
    end

    if (halted) begin
      for (int h = 0; h < 3; h++) push('0, rbit(), rbit(), 0, 0);
    end
  endtask

  task automatic drain(input int max);
    int     k;
    entry_t e;
    ctl_t   obs;
    k = 0;
    while (sb.size() > 0 && (max < 0 || k < max)) begin
      e = sb.pop_front();
      @(negedge Clock);
      obs = sample();
      n_vec++;
      if (obs !== e.exp) begin
        n_miss++;
        $display("FAIL ctl_vec t=%0t got=%h expected=%h", $time, obs, e.exp);
      end
      if (obs.pcin) pcin_seen++;
      bus.Mem_ready = e.mr;
      bus.Stop      = e.stp;
      @(posedge Clock);
      if (e.ld) begin
        #1;
        bus.IR = e.ir;
      end
      k++;
    end
  endtask

  task automatic test_reset();
    ctl_t obs;
    Clear = 1'b0;
    bus.IR = 32'h0;
    bus.Mem_ready = 1'b0;
    bus.Stop = 1'b0;
    sb.delete();
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    obs = sample();
    n_vec++;
    if (obs !== ctl_t'('0)) begin
      n_miss++;
      $display("FAIL reset_outputs got=%h expected=0", obs);
    end
    Clear = 1'b1;
  endtask

  task automatic test_shl();
    gen(32'h489A8000, 0, 0);
    drain(-1);
  endtask

  task automatic test_mul();
    gen(32'h78000000 | (32'd3 << 19) | (32'd5 << 15), 0, 1);
    drain(-1);
  endtask

  task automatic test_mem_wait();
    pcin_seen = 0;
    gen({5'b00011, 4'd4, 4'd6, 4'd9, 15'd0}, 3, 1);
    drain(-1);
    n_vec++;
    if (pcin_seen !== 1) begin
      n_miss++;
      $display("FAIL pcin_once got=%0d expected=1", pcin_seen);
    end
  endtask

  task automatic test_neg();
    gen({5'b10001, 4'd2, 4'd7, 4'd0, 15'd0}, 0, 0);
    drain(-1);
  endtask

  task automatic test_illegal();
    gen({5'b11111, 4'd1, 4'd2, 4'd3, 15'd0}, 0, 0);
    gen({5'b00100, 4'd15, 4'd0, 4'd14, 15'd0}, 1, 0);
    drain(-1);
  endtask

  task automatic test_back_to_back();
    logic [4:0] ops [0:12];
    logic [31:0] instr;
    ops = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001,
            5'b01010, 5'b01011, 5'b10001, 5'b10010, 5'b01111, 5'b00000};
    for (int i = 0; i < 12; i++) begin
      instr = {ops[$urandom_range(0, 12)], 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 15'($urandom)};
      gen(instr, $urandom_range(0, 2), 1);
    end
    drain(-1);
  endtask

  task automatic test_halt_op();
    gen({5'b11011, 4'd1, 4'd1, 4'd1, 15'd0}, 0, 0);
    drain(-1);
  endtask

  task automatic test_stop();
    gen({5'b00011, 4'd3, 4'd1, 4'd2, 15'd0}, 0, 2);
    drain(-1);
  endtask

  task automatic test_clear_mid();
    ctl_t obs;
    gen({5'b00011, 4'd5, 4'd6, 4'd7, 15'd0}, 0, 0);
    drain(4);
    @(negedge Clock);
    obs = sample();
    n_vec++;
    if (obs !== sb[0].exp) begin
      n_miss++;
      $display("FAIL clear_pre_t4 got=%h expected=%h", obs, sb[0].exp);
    end
    Clear = 1'b0;
    #1;
    obs = sample();
    n_vec++;
    if (obs !== ctl_t'('0)) begin
      n_miss++;
      $display("FAIL clear_async got=%h expected=0", obs);
    end
    sb.delete();
    @(posedge Clock);
    @(negedge Clock);
    Clear = 1'b1;
    gen({5'b01001, 4'd8, 4'd9, 4'd10, 15'd0}, 0, 0);
    drain(-1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_shl();
    test_mul();
    test_mem_wait();
    test_neg();
    test_illegal();
    test_back_to_back();
    test_halt_op();
    test_reset();
    test_stop();
    test_reset();
    test_clear_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Hardwired control sequencer for the Mini SRC datapath. It fetches instructions through PC/MAR/MDR/IR and executes register-to-register ALU instructions by driving the datapath's load, drive, IncPC, Read and OP controls cycle by cycle. It sits directly upstream of `datapath` and replaces bench-driven control sequences with a synthesizable FSM; `IR` is fed back from the datapath.

## Interface
Parameters:
- `HALT_OP`, default 5'b11011, opcode that stops the sequencer.

Ports:
- `Clock`  in  1  system clock; all state changes on its rising edge.
- `Clear`  in  1  asynchronous, active-low reset.
- `IR`  in  32  instruction register contents: `IR[31:27]` opcode, `IR[26:23]` Ra, `IR[22:19]` Rb, `IR[18:15]` Rc.
- `Mem_ready`  in  1  memory read data valid on `Mdatain` this cycle.
- `Stop`  in  1  request to halt at the next instruction boundary.
- `Rin`  out  16  one-hot register load; bit n drives `Rn`in.
- `Rout`  out  16  one-hot register drive; bit n drives `Rn`out.
- `PCin`, `PCout`, `IncPC`, `MARin`, `MDRin`, `MDRout`, `IRin`, `Yin`, `ZLowin`, `ZHighin`, `ZLowout`, `ZHighout`, `HIin`, `LOin`, `Read`  out  1 each  datapath controls with the same meaning as the datapath ports of the same name.
- `OP`  out  5  ALU operation code.
- `Run`  out  1  high while the sequencer is executing; low in RST and HALT.

## Operation
- Opcode classes:
  - binary: 00011 add, 00100 sub, 00101 and, 00110 or, 00111 shr, 01000 shra, 01001 shl, 01010 ror, 01011 rol.
  - unary: 10001 neg, 10010 not.
  - wide: 01111 mul, 10000 div.
  - `HALT_OP`.
  - Any other opcode is illegal.
- States: RST, T0, T1, T2, T3, T4, T5, T6, HALT. Outputs not listed for a state are 0.
- RST: all outputs 0. The first rising edge with `Clear` high moves to T0.
- T0: `PCout`, `MARin`, `IncPC`, `PCin`. The PC increments at the end of T0. Next state is T1.
- T1: `Read`, `MDRin`, `Run`. The state holds while `Mem_ready`=0 and moves to T2 on an edge where `Mem_ready`=1.
- T2: `MDRout`, `IRin`. `IR` is valid from the next cycle.
- Decode at the T2→next edge uses the pre-load `IR`, so the transition out of T2 always goes to a fixed state D. In D, `IR` is stable. This means T3 is the decode cycle:
  - T3 for binary or wide: `Rout[Rb]`, `Yin`; next state T4.
  - T3 for unary: no datapath controls asserted; next state T4.
  - T3 for `HALT_OP`: next state HALT.
  - T3 for an illegal opcode: the instruction is a NOP; next state T0, or HALT if `Stop`=1.
- T4:
  - binary: `Rout[Rc]`, `OP`=opcode, `ZLowin`.
  - unary: `Rout[Rb]`, `OP`=opcode, `ZLowin`.
  - wide: `Rout[Rc]`, `OP`=opcode, `ZLowin`, `ZHighin`.
  - Next state T5.
- T5:
  - binary or unary: `ZLowout`, `Rin[Ra]`.
  - wide: `ZLowout`, `LOin`; next state T6.
- T6 (wide only): `ZHighout`, `HIin`.
- End of instruction (T5 for binary/unary, T6 for wide): next state is T0 if `Stop`=0, HALT if `Stop`=1.
- HALT: all outputs 0 and `Run`=0. The state is held until `Clear` is asserted.
- `Run`=1 in T0 through T6.
- `OP` is 0 in every state except T4.
- At most one bit of `Rin` and one bit of `Rout` is ever high. Writes to R0 are not masked.

## Timing
- Outputs are decoded from the state register and `IR` (Moore with respect to state). They change only after a rising edge or an asynchronous reset. The datapath captures them on the following rising edge.
- `Clear` low forces RST immediately, from any state including mid-instruction or T1 wait. Every output goes to 0 within the same cycle.
- Latency with `Mem_ready` high in the first T1 cycle:
  - binary/unary: 6 cycles (T0–T5).
  - wide: 7 cycles (T0–T6).
  - illegal: 4 cycles (T0–T3).
  - Each extra T1 wait cycle adds 1.
- `Stop` is sampled only at instruction-end edges; assertion mid-instruction lets the current instruction complete.
- `Mem_ready` is ignored outside T1.

## Test plan
- Reset, then `IR`=0x489A8000 (shl R1,R3,R5), `Mem_ready`=1: cycles show T0 `PCout`/`MARin`/`IncPC`/`PCin`; T1 `Read`/`MDRin`; T2 `MDRout`/`IRin`; T3 `Rout`=0x0008, `Yin`; T4 `Rout`=0x0020, `OP`=01001, `ZLowin`; T5 `ZLowout`, `Rin`=0x0002; then back to T0.
- mul 0x78000000|Rb=3|Rc=5 (opcode 01111): T4 asserts `ZLowin` and `ZHighin`; T5 `ZLowout`+`LOin`; T6 `ZHighout`+`HIin`; `Rin`=0 throughout.
- `Mem_ready` low for 3 cycles in T1: `Read`/`MDRin` held for 4 cycles; `PCin` asserted only once per instruction.
- neg (opcode 10001, Ra=2, Rb=7): T3 asserts no `Yin`; T4 `Rout`=0x0080, `OP`=10001; T5 `Rin`=0x0004.
- Illegal opcode 11111: returns to T0 after T3 with no `Rin`/`Yin`/`Z*` pulses. `HALT_OP`: `Run` falls after T3 and stays low.
- `Stop` raised during T4 of an add: T5 completes, then HALT. `Clear` pulsed low during T4: outputs 0 immediately; fetch restarts from T0 after release.
